// File: rtl/accum_cpu_ng.sv
// rtl/accum_cpu_ng.sv - accumulator CPU: one command per handshake, register file, pointer, Z/C flags, store port
// Illegal opcodes or register selects jam the core until reset.
module accum_cpu_ng #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd,
  input  logic [DATA_W-1:0] arg,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              jam,
  output logic [7:0]        jam_cmd
);

  typedef enum logic [1:0] {ST_RUN, ST_STORE, ST_JAM} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   regs [4];
  logic [ADDR_W-1:0]   ptr;
  logic [3:0]          op;
  logic [1:0]          sel;
  logic                illegal;
  logic                fire;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   res;
  logic [DATA_W:0]     sum;
  logic                c_nxt;
  logic                wr_reg;

  assign op      = cmd[7:4];
  assign sel     = cmd[1:0];
  assign illegal = (op > 4'h8) || ({1'b0, sel} >= 3'(NREGS));
  assign fire    = cmd_valid & cmd_ready;
  assign cur     = regs[sel];

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (fire) begin
          if (illegal)         state_nxt = ST_JAM;
          else if (op == 4'h6) state_nxt = ST_STORE;
        end
      end
      ST_STORE: if (wr_ready) state_nxt = ST_RUN;
      ST_JAM:   state_nxt = ST_JAM;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    cmd_ready = rstn & (state == ST_RUN);
    wr_valid  = (state == ST_STORE);
    jam       = (state == ST_JAM);
  end

  // The carry-in term is only live for ADC; ADD shares the same adder.
  always_comb begin
    res    = cur;
    c_nxt  = flag_c;
    wr_reg = 1'b0;
    sum    = {1'b0, cur} + {1'b0, arg} + {{DATA_W{1'b0}}, (op == 4'h8) & flag_c};
    case (op)
      4'h0: begin res = '0;   c_nxt = 1'b0; wr_reg = 1'b1; end
      4'h1: begin res = ~cur; wr_reg = 1'b1; end
      4'h2: begin res = arg;  wr_reg = 1'b1; end
      4'h4, 4'h8: begin {c_nxt, res} = sum; wr_reg = 1'b1; end
      4'h5: begin res = cur - arg; c_nxt = (arg > cur); wr_reg = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      ptr     <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      jam_cmd <= '0;
      wr_addr <= '0;
      wr_data <= {(DATA_W/2){2'b01}};
    end else if (fire) begin
      if (illegal) begin
        jam_cmd <= cmd;
        wr_addr <= '0;
        wr_data <= '1;
      end else begin
        if (wr_reg) begin
          regs[sel] <= res;
          flag_z    <= (res == '0);
          flag_c    <= c_nxt;
        end
        if (op == 4'h3) ptr <= ADDR_W'(arg);
        if (op == 4'h6) begin
          wr_addr <= ptr;
          wr_data <= cur;
          if (cmd[2]) ptr <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_cpu_ng.sv
// tb/tb_accum_cpu_ng.sv - self-checking bench for accum_cpu_ng: directed table, corner sequences, random vs model
module tb_accum_cpu_ng;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       wr_ready;
  logic       cmd_ready, wr_valid, flag_z, flag_c, jam;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, jam_cmd;
  logic       cmd_ready2, wr_valid2, flag_z2, flag_c2, jam2;
  logic [3:0] wr_addr2;
  logic [7:0] wr_data2, jam_cmd2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accum_cpu_ng dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .arg(arg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_z(flag_z), .flag_c(flag_c), .jam(jam), .jam_cmd(jam_cmd)
  );

  accum_cpu_ng #(.DATA_W(8), .ADDR_W(4), .NREGS(2)) dut2 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd(cmd), .arg(arg),
    .wr_valid(wr_valid2), .wr_ready(wr_ready), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .flag_z(flag_z2), .flag_c(flag_c2), .jam(jam2), .jam_cmd(jam_cmd2)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       z;
    logic       c;
    logic       st;
    logic [3:0] st_addr;
    logic [7:0] st_data;
  } vec_t;

  vec_t vecs [20];

  int m_r [4];
  int m_ptr, m_z, m_c, m_jam, m_jcmd, m_pend, m_waddr, m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for cmd_ready, transfers one command, returns at the following negedge.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int k;
    @(posedge clk); #1;
    for (k = 0; k < 20; k++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    if (k == 20) chk("ready_timeout", 0, 1);
    cmd = c; arg = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_ptr = 0; m_z = 0; m_c = 0; m_jam = 0; m_jcmd = 0;
    m_pend = 0; m_waddr = 0; m_wdata = 8'h55;
  endtask

  task automatic model_step();
    int op, sel, s;
    bit fire;
    if (!rstn) begin
      model_reset();
      return;
    end
    fire = cmd_valid && !m_jam && !m_pend;
    if (m_pend && wr_ready) m_pend = 0;
    if (!fire) return;
    op = cmd / 16;
    sel = cmd % 4;
    if (op > 8 || sel >= 4) begin
      m_jam = 1; m_jcmd = cmd; m_waddr = 0; m_wdata = 255;
      return;
    end
    case (op)
      0: begin m_r[sel] = 0; m_c = 0; end
      1: m_r[sel] = 255 - m_r[sel];
      2: m_r[sel] = arg;
      3: m_ptr = arg % 16;
      4: begin s = m_r[sel] + arg; m_c = s / 256; m_r[sel] = s % 256; end
      5: begin m_c = (arg > m_r[sel]) ? 1 : 0; m_r[sel] = (m_r[sel] - arg + 256) % 256; end
      6: begin
        m_pend = 1; m_waddr = m_ptr; m_wdata = m_r[sel];
        if (cmd[2]) m_ptr = (m_ptr + 1) % 16;
      end
      8: begin s = m_r[sel] + arg + m_c; m_c = s / 256; m_r[sel] = s % 256; end
      default: ;
    endcase
    if (op inside {0, 1, 2, 4, 5, 8}) m_z = (m_r[sel] == 0) ? 1 : 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h20, 8'h05, 0, 0, 0, 4'h0, 8'h00};
    vecs[1]  = '{8'h40, 8'hFE, 0, 1, 0, 4'h0, 8'h00};
    vecs[2]  = '{8'h60, 8'h00, 0, 1, 1, 4'h0, 8'h03};
    vecs[3]  = '{8'h20, 8'h03, 0, 1, 0, 4'h0, 8'h00};
    vecs[4]  = '{8'h50, 8'h03, 1, 0, 0, 4'h0, 8'h00};
    vecs[5]  = '{8'h50, 8'h01, 0, 1, 0, 4'h0, 8'h00};
    vecs[6]  = '{8'h60, 8'h00, 0, 1, 1, 4'h0, 8'hFF};
    vecs[7]  = '{8'h21, 8'hAA, 0, 1, 0, 4'h0, 8'h00};
    vecs[8]  = '{8'h30, 8'h0E, 0, 1, 0, 4'h0, 8'h00};
    vecs[9]  = '{8'h65, 8'h00, 0, 1, 1, 4'hE, 8'hAA};
    vecs[10] = '{8'h65, 8'h00, 0, 1, 1, 4'hF, 8'hAA};
    vecs[11] = '{8'h65, 8'h00, 0, 1, 1, 4'h0, 8'hAA};
    vecs[12] = '{8'h61, 8'h00, 0, 1, 1, 4'h1, 8'hAA};
    vecs[13] = '{8'h20, 8'hFF, 0, 1, 0, 4'h0, 8'h00};
    vecs[14] = '{8'h40, 8'h01, 1, 1, 0, 4'h0, 8'h00};
    vecs[15] = '{8'h80, 8'h00, 0, 0, 0, 4'h0, 8'h00};
    vecs[16] = '{8'h00, 8'h00, 1, 0, 0, 4'h0, 8'h00};
    vecs[17] = '{8'h19, 8'h00, 0, 0, 0, 4'h0, 8'h00};
    vecs[18] = '{8'h61, 8'h00, 0, 0, 1, 4'h1, 8'h55};
    vecs[19] = '{8'h70, 8'h00, 0, 0, 0, 4'h0, 8'h00};

    rstn = 1'b0; cmd_valid = 1'b0; cmd = '0; arg = '0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", cmd_ready, 0);
    chk("rst_wr_data", wr_data, 8'h55);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    chk("rst_jam", {jam, jam_cmd}, 0);
    chk("rst2_outs", {wr_valid2, wr_addr2, wr_data2, flag_z2, flag_c2, jam2, jam_cmd2}, {1'b0, 4'h0, 8'h55, 2'b00, 1'b0, 8'h00});
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready_high", cmd_ready, 1);
    chk("rst2_ready_high", cmd_ready2, 1);

    // R3 is legal with four registers and illegal with two.
    send(8'h23, 8'h11);
    chk("r3_no_jam", jam, 0);
    chk("r3_ready", cmd_ready, 1);
    chk("nregs2_jam", jam2, 1);
    chk("nregs2_jam_cmd", jam_cmd2, 8'h23);
    chk("nregs2_wr_data", {wr_addr2, wr_data2}, {4'h0, 8'hFF});
    chk("nregs2_ready", cmd_ready2, 0);

    for (int i = 0; i < 20; i++) begin
      send(vecs[i].cmd, vecs[i].arg);
      chk($sformatf("vec%0d_z", i), flag_z, vecs[i].z);
      chk($sformatf("vec%0d_c", i), flag_c, vecs[i].c);
      chk($sformatf("vec%0d_wr_valid", i), wr_valid, vecs[i].st);
      if (vecs[i].st) begin
        chk($sformatf("vec%0d_ready", i), cmd_ready, 0);
        chk($sformatf("vec%0d_wr_addr", i), wr_addr, vecs[i].st_addr);
        chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].st_data);
      end
    end

    // Backpressure: store held for five cycles while a new command waits.
    @(posedge clk); #1;
    cmd = 8'h61; arg = 8'h00; cmd_valid = 1'b1; wr_ready = 1'b0;
    @(posedge clk); #1;
    cmd = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_wr_valid", wr_valid, 1);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_addr_data", {wr_addr, wr_data}, {4'h1, 8'h55});
      chk("bp_z_held", flag_z, 0);
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_valid", wr_valid, 0);
    chk("bp_done_ready", cmd_ready, 1);
    chk("bp_done_z", flag_z, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_z", flag_z, 1);
    chk("bp_next_c", flag_c, 0);

    // Jam on illegal opcode; later commands are ignored until reset.
    send(8'h90, 8'h42);
    chk("jam_flag", jam, 1);
    chk("jam_cmd", jam_cmd, 8'h90);
    chk("jam_wr", {wr_valid, wr_addr, wr_data}, {1'b0, 4'h0, 8'hFF});
    chk("jam_ready", cmd_ready, 0);
    @(posedge clk); #1;
    cmd = 8'h60; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("jam_hold", {jam, wr_valid, cmd_ready, wr_data, flag_z}, {3'b100, 8'hFF, 1'b1});
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("jrst_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("jrst_outs", {jam, jam_cmd, wr_valid, wr_addr, wr_data, flag_z, flag_c}, {1'b0, 8'h00, 1'b0, 4'h0, 8'h55, 2'b00});
    chk("jrst_ready", cmd_ready, 1);
    send(8'h60, 8'h00);
    chk("jrst_reg_zero", {wr_valid, wr_addr, wr_data}, {1'b1, 4'h0, 8'h00});

    // Randomized phase against the reference model.
    @(posedge clk); #1;
    rstn = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rstn = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] op_r;
      op_r = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      rstn = ($urandom_range(0, 63) != 0);
      cmd_valid = $urandom_range(0, 1);
      cmd = {op_r, 4'($urandom)};
      arg = 8'($urandom);
      wr_ready = $urandom_range(0, 1);
      @(negedge clk);
      chk("rnd_ready", cmd_ready, (rstn && !m_jam && !m_pend) ? 1 : 0);
      chk("rnd_wr_valid", wr_valid, m_pend);
      chk("rnd_wr_addr", wr_addr, m_waddr);
      chk("rnd_wr_data", wr_data, m_wdata);
      chk("rnd_z", flag_z, m_z);
      chk("rnd_c", flag_c, m_c);
      chk("rnd_jam", {jam, jam_cmd}, {m_jam[0], m_jcmd[7:0]});
      model_step();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
